// File: rtl/sys_step_ctrl.sv
// Run/step/halt controller producing a one-cycle CPU clock enable, with optional
// pulse counter enabled by defining SYS_CYCLE_CNT_EN.
module sys_step_ctrl #(
    parameter int unsigned divisor = 1
) (
    input  logic        clk,
    input  logic        SYS_reset,
    input  logic        SYS_run,
    input  logic        SYS_step,
    input  logic        cpu_halt,
    output logic        cpu_en,
    output logic [1:0]  SYS_state,
    output logic [31:0] SYS_cycles
);

    localparam int unsigned DIV_W   = 32;
    localparam int unsigned CYC_W   = 32;
    // A divisor of 0 behaves like 1, so the terminal count is 0 in both cases.
    localparam logic [DIV_W-1:0] DIV_LAST = (divisor == 0) ? '0 : DIV_W'(divisor - 1);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] STEP   = 2'b10;
    localparam logic [1:0] HALTED = 2'b11;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             en_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             step_q;
    logic             step_edge_c;
    logic             tick_c;

    assign step_edge_c = SYS_step & ~step_q;
    assign tick_c      = (div_cnt == DIV_LAST);
    assign SYS_state   = state;

    // State and enable registers; step_q resets high so a held step is not an edge.
    always_ff @(posedge clk) begin
        if (SYS_reset) begin
            state   <= IDLE;
            cpu_en  <= 1'b0;
            div_cnt <= '0;
            step_q  <= 1'b1;
        end else begin
            state   <= state_nxt;
            cpu_en  <= en_nxt;
            div_cnt <= div_nxt;
            step_q  <= SYS_step;
        end
    end

    // Next state, next enable and divider update.
    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        div_nxt   = '0;
        case (state)
            IDLE: begin
                if (SYS_run) begin
                    state_nxt = RUN;
                end else if (step_edge_c) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                if (cpu_halt) begin
                    state_nxt = HALTED;
                end else if (!SYS_run) begin
                    state_nxt = IDLE;
                end else begin
                    en_nxt  = tick_c;
                    div_nxt = tick_c ? '0 : div_cnt + DIV_W'(1);
                end
            end
            STEP: begin
                if (cpu_halt) begin
                    state_nxt = HALTED;
                end else begin
                    en_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = HALTED;
            end
        endcase
    end

`ifdef SYS_CYCLE_CNT_EN
    logic [CYC_W-1:0] cycles_q;

    // Counts issued enable pulses; wraps naturally at the register width.
    always_ff @(posedge clk) begin
        if (SYS_reset) begin
            cycles_q <= '0;
        end else if (cpu_en) begin
            cycles_q <= cycles_q + CYC_W'(1);
        end
    end

    assign SYS_cycles = cycles_q;
`else
    assign SYS_cycles = CYC_W'(0);
`endif

endmodule

// File: tb/tb_sys_step_ctrl.sv
// Self-checking bench for sys_step_ctrl: directed table, latency sequences and
// randomized stimulus against a behavioural model, for divisors 1, 4 and 0.
module tb_sys_step_ctrl;

`ifdef SYS_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, run, step, halt;
    logic        en  [3];
    logic [1:0]  st  [3];
    logic [31:0] cyc [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sys_step_ctrl #(.divisor(1)) dut_a (
        .clk(clk), .SYS_reset(rst), .SYS_run(run), .SYS_step(step), .cpu_halt(halt),
        .cpu_en(en[0]), .SYS_state(st[0]), .SYS_cycles(cyc[0]));
    sys_step_ctrl #(.divisor(4)) dut_b (
        .clk(clk), .SYS_reset(rst), .SYS_run(run), .SYS_step(step), .cpu_halt(halt),
        .cpu_en(en[1]), .SYS_state(st[1]), .SYS_cycles(cyc[1]));
    sys_step_ctrl #(.divisor(0)) dut_z (
        .clk(clk), .SYS_reset(rst), .SYS_run(run), .SYS_step(step), .cpu_halt(halt),
        .cpu_en(en[2]), .SYS_state(st[2]), .SYS_cycles(cyc[2]));

    // Reference model: mode 0 idle, 1 running, 2 stepping, 3 halted.
    int unsigned dv      [3] = '{1, 4, 1};
    int unsigned m_mode  [3];
    int unsigned m_age   [3];
    logic        m_en    [3];
    logic [31:0] m_cyc   [3];
    logic        m_stepq [3];

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic edge_seen;
            if (rst) begin
                m_mode[k] = 0; m_en[k] = 1'b0; m_age[k] = 0;
                m_cyc[k] = 32'd0; m_stepq[k] = 1'b1;
            end else begin
                edge_seen  = step && !m_stepq[k];
                m_stepq[k] = step;
                if (m_en[k]) m_cyc[k] = m_cyc[k] + 32'd1;
                case (m_mode[k])
                    0: begin
                        m_en[k] = 1'b0;
                        if (run) begin m_mode[k] = 1; m_age[k] = 0; end
                        else if (edge_seen) m_mode[k] = 2;
                    end
                    1: begin
                        m_en[k] = 1'b0;
                        if (halt) m_mode[k] = 3;
                        else if (!run) m_mode[k] = 0;
                        else begin
                            m_age[k] = m_age[k] + 1;
                            m_en[k]  = (m_age[k] % dv[k]) == 0;
                        end
                    end
                    2: begin
                        if (halt) begin m_mode[k] = 3; m_en[k] = 1'b0; end
                        else begin m_mode[k] = 0; m_en[k] = 1'b1; end
                    end
                    default: m_en[k] = 1'b0;
                endcase
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_state[%0d]", k), 32'(st[k]), 32'(m_mode[k]));
            chk($sformatf("model_en[%0d]", k), 32'(en[k]), 32'(m_en[k]));
            chk($sformatf("model_cycles[%0d]", k), cyc[k], CNT_EN ? m_cyc[k] : 32'd0);
        end
    endtask

    task automatic drive(input logic r, input logic ru, input logic s, input logic h);
        rst = r; run = ru; step = s; halt = h;
    endtask

    typedef struct {
        logic       rst, run, step, halt;
        logic [1:0] exp_state;
        logic       exp_en;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int entry, first, last, pulses;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Directed vectors for the divisor-1 instance: reset, step, halt, reset-with-step.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].run, tbl[i].step, tbl[i].halt);
            cycle();
            chk($sformatf("tbl_state[%0d]", i), 32'(st[0]), 32'(tbl[i].exp_state));
            chk($sformatf("tbl_en[%0d]", i), 32'(en[0]), 32'(tbl[i].exp_en));
        end
        chk("reset_cycles", cyc[0], 32'd0);

        // Divisor 1: run for exactly 10 edges gives 9 consecutive pulses.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (en[0]) pulses++;
            if (i >= 2) chk($sformatf("div1_continuous[%0d]", i), 32'(en[0]), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("div1_pulses", 32'(pulses), 32'd9);
        chk("div1_idle", 32'(st[0]), 32'd0);
        chk("div1_cycles", cyc[0], CNT_EN ? 32'd9 : 32'd0);
        chk("div0_cycles", cyc[2], CNT_EN ? 32'd9 : 32'd0);

        // Divisor 4: first pulse 4 cycles after RUN is visible, then every 4.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        entry = -1; first = -1; last = -1; pulses = 0;
        for (int i = 1; i <= 21; i++) begin
            cycle();
            if (st[1] == 2'b01 && entry < 0) entry = i;
            if (en[1]) begin
                if (first < 0) first = i;
                else chk("div4_spacing", 32'(i - last), 32'd4);
                last = i;
                pulses++;
            end
        end
        cycle();
        chk("div4_entry", 32'(entry), 32'd1);
        chk("div4_latency", 32'(first - entry), 32'd4);
        chk("div4_pulses", 32'(pulses), 32'd5);
        chk("div4_cycles", cyc[1], CNT_EN ? 32'd5 : 32'd0);

        // Divisor 4: reset mid-count, then a fresh run restarts the full latency.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("rst_mid_state", 32'(st[1]), 32'd0);
        chk("rst_mid_en", 32'(en[1]), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        entry = -1; first = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (st[1] == 2'b01 && entry < 0) entry = i;
            if (en[1] && first < 0) first = i;
        end
        chk("rerun_latency", 32'(first - entry), 32'd4);

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 29) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys_step_ctrl.md
SYS_STEP_CTRL -- requirements
Module: sys_step_ctrl

Interface
REQ-001 Parameter: divisor, default 1, CPU clock-enable period in clk cycles while running; value 0 SHALL be treated as 1.
REQ-002 Port: clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 Port: SYS_reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: SYS_run  input  1  level request for continuous execution.
REQ-005 Port: SYS_step  input  1  raw single-step request; only its rising edge is acted on.
REQ-006 Port: cpu_halt  input  1  halt indication from the CPU datapath (halt instruction / end of program).
REQ-007 Port: cpu_en  output  1  registered one-cycle clock-enable pulse gating CPU state update.
REQ-008 Port: SYS_state  output  2  current FSM state encoding (IDLE=00, RUN=01, STEP=10, HALTED=11).
REQ-009 Port: SYS_cycles  output  32  count of cpu_en pulses issued since reset.

Function
REQ-010 Internal divider div_cnt (32 bit) SHALL count 0..divisor-1 only in RUN, wrap to 0, and be cleared in every other state; tick = (div_cnt == divisor-1).
REQ-011 Step edge SHALL be SYS_step & ~step_q, with step_q a registered copy of SYS_step; edges arriving outside IDLE SHALL be discarded, not queued.
REQ-012 IDLE: SYS_run=1 -> RUN (priority over step edge); else step edge -> STEP; else stay; cpu_en next cycle 0.
REQ-013 RUN: cpu_halt=1 -> HALTED with no pulse; else SYS_run=0 -> IDLE with no pulse; else stay, and tick SHALL set cpu_en=1 for the following cycle.
REQ-014 STEP: cpu_halt=1 -> HALTED with no pulse; else cpu_en=1 for exactly the following cycle and state -> IDLE.
REQ-015 HALTED: terminal; SYS_run, SYS_step, cpu_halt ignored; cpu_en held 0 until SYS_reset.
REQ-016 cpu_en SHALL never be high for more than one consecutive cycle unless divisor=1 in RUN (then high every cycle from the cycle after RUN entry).
REQ-017 Latency: first RUN pulse SHALL appear divisor cycles after SYS_state first reads RUN; STEP pulse SHALL appear one cycle after SYS_state reads STEP.
REQ-018 SYS_cycles SHALL increment by 1 on each cycle where cpu_en=1 and wrap from 32'hFFFFFFFF to 0.

Reset
REQ-019 On SYS_reset=1 at a clock edge: state IDLE, cpu_en 0, div_cnt 0, SYS_cycles 0, step_q 1.
REQ-020 step_q reset to 1 SHALL prevent a SYS_step held high across reset from producing a step.
REQ-021 Reset SHALL take priority over every other input in any state, including mid-RUN and HALTED.

Configuration
REQ-022 Macro SYS_CYCLE_CNT_EN: defined -> SYS_cycles counter implemented per REQ-018; undefined -> no counter register, SYS_cycles tied to 0, port retained, all other behaviour identical.

Verification
REQ-023 SYS_reset pulse with all inputs 0 -> SYS_state=00, cpu_en=0, SYS_cycles=0 next cycle.
REQ-024 divisor=1, SYS_run high for exactly 10 sampled edges from IDLE -> cpu_en high exactly 9 consecutive cycles, SYS_state returns 00, SYS_cycles=9.
REQ-025 divisor=4, SYS_run held high -> first cpu_en 4 cycles after SYS_state=01, then one pulse every 4 cycles; SYS_cycles=5 after 5 pulses.
REQ-026 SYS_step held high 20 cycles from IDLE -> exactly one cpu_en pulse, SYS_state sequence 00,10,00; step high across SYS_reset -> zero pulses.
REQ-027 divisor=1, RUN, cpu_halt=1 for one cycle -> SYS_state=11 next cycle, no further cpu_en despite SYS_run=1 and step edges; SYS_reset -> 00, SYS_cycles=0.
REQ-028 divisor=4, SYS_reset asserted with div_cnt=2 in RUN -> IDLE, no pulse; re-run -> first pulse 4 cycles after RUN entry; build with and without SYS_CYCLE_CNT_EN, SYS_cycles stays 0 in the latter.
